// File: rtl/piano_pkg.sv
// Shared types and constants for the piano key drawing slice.
// Key colours cycle red, green, blue across the keyboard.
package piano_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW
    } state_t;

    localparam int BLOCK_W = 8;
    localparam int BLOCK_H = 8;
    localparam logic [2:0] COL_BLACK = 3'b000;

    function automatic logic [2:0] key_colour(input int i);
        logic [2:0] c;
        case (i % 3)
            0:       c = 3'b100;
            1:       c = 3'b010;
            default: c = 3'b001;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/block_filler.sv
// Walks one 8x8 block row by row, emitting a registered
// pixel address and plot strobe for each of the 64 pixels.
module block_filler
    import piano_pkg::*;
#(
    parameter int Y_TOP = 87
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       plot,
    output logic       done
);

    localparam logic [5:0] LAST = 6'(BLOCK_W * BLOCK_H - 1);

    logic [5:0] count_q, count_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       plot_q, plot_d;

    always_comb begin
        count_d = count_q;
        x_d     = x_q;
        y_d     = y_q;
        plot_d  = plot_q;
        done    = plot_q && (count_q == LAST);
        if (start) begin
            count_d = '0;
            x_d     = base_x;
            y_d     = base_y;
            plot_d  = 1'b1;
        end else if (plot_q) begin
            if (done) begin
                plot_d = 1'b0;
            end else begin
                count_d = count_q + 6'd1;
                x_d     = base_x + {5'b0, count_d[2:0]};
                y_d     = base_y + {4'b0, count_d[5:3]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
            x_q     <= '0;
            y_q     <= 7'(Y_TOP);
            plot_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            x_q     <= x_d;
            y_q     <= y_d;
            plot_q  <= plot_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign plot = plot_q;

endmodule

// File: rtl/key_draw_scheduler.sv
// Queues key redraw requests and shares one plot port between keys
// using a round-robin grant, one 8x8 block fill per grant.
module key_draw_scheduler
    import piano_pkg::*;
#(
    parameter int NUM_KEYS  = 3,
    parameter int KEY_PITCH = 64,
    parameter int Y_TOP     = 87
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                enable,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [2:0]          colour,
    output logic                plot,
    output logic                busy,
    output logic [NUM_KEYS-1:0] pending
);

    localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    state_t state_q, state_d;

    logic [NUM_KEYS-1:0] key_prev_q, key_prev_d;
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [NUM_KEYS-1:0] clr;
    logic [IW-1:0]       rr_q, rr_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic [IW-1:0]       gnt_c;
    logic [IW-1:0]       base_sel;
    logic [2:0]          colour_q, colour_d;
    logic                found;
    logic                start;
    logic                fill_done;
    logic [7:0]          base_x;
    logic [6:0]          base_y;

    // First pending key at or after the round-robin pointer, wrapping.
    always_comb begin
        gnt_c = rr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % NUM_KEYS;
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                gnt_c = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable && |pending_q) state_d = LOAD;
            LOAD:    state_d = DRAW;
            DRAW:    if (fill_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // New edges are OR-ed in after the grant clear so they are never lost.
    always_comb begin
        key_prev_d = key_n;
        clr        = '0;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        colour_d   = colour_q;
        if (state_q == LOAD) begin
            clr[gnt_c] = 1'b1;
            gnt_d      = gnt_c;
            if (int'(gnt_c) == NUM_KEYS - 1) begin
                rr_d = '0;
            end else begin
                rr_d = gnt_c + IW'(1);
            end
            colour_d = key_n[gnt_c] ? COL_BLACK : key_colour(int'(gnt_c));
        end
        pending_d = (pending_q & ~clr) | (key_n ^ key_prev_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_prev_q <= '1;
            pending_q  <= '1;
            rr_q       <= '0;
            gnt_q      <= '0;
            colour_q   <= COL_BLACK;
        end else begin
            key_prev_q <= key_prev_d;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            colour_q   <= colour_d;
        end
    end

    always_comb begin
        start    = (state_q == LOAD);
        busy     = (state_q != IDLE);
        base_sel = start ? gnt_c : gnt_q;
        base_x   = 8'(int'(base_sel) * KEY_PITCH);
        base_y   = 7'(Y_TOP);
    end

    block_filler #(
        .Y_TOP(Y_TOP)
    ) u_fill (
        .clk   (clk),
        .resetn(resetn),
        .start (start),
        .base_x(base_x),
        .base_y(base_y),
        .x     (x),
        .y     (y),
        .plot  (plot),
        .done  (fill_done)
    );

    assign colour  = colour_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_key_draw_scheduler.sv
// Directed bench for key_draw_scheduler: single-key vector table
// plus hand-written multi-key, enable and reset sequences.
module tb_key_draw_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b1;
    logic [2:0] key_n = 3'b111;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic [2:0] pending;

    int vecs = 0;
    int errs = 0;
    int plot_cnt = 0;

    typedef struct {
        logic [2:0] kn;
        int         key;
        logic [2:0] col;
    } vec_t;

    vec_t tbl[6];

    key_draw_scheduler #(
        .NUM_KEYS (3),
        .KEY_PITCH(64),
        .Y_TOP    (87)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .key_n  (key_n),
        .enable (enable),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .pending(pending)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (plot === 1'b1) plot_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_plot(input string name, output int n);
        n = 0;
        while (plot !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        vecs++;
        if (plot !== 1'b1) begin
            errs++;
            $display("FAIL %s: plot timeout got %b expected 1", name, plot);
        end
    endtask

    task automatic check_fill(input string name, input int key,
                              input logic [2:0] col, input int chg_at,
                              input logic [2:0] chg_val);
        int bad;
        logic [7:0] ex;
        logic [6:0] ey;
        bad = -1;
        for (int i = 0; i < 64; i++) begin
            ex = 8'(key * 64 + i % 8);
            ey = 7'(87 + i / 8);
            if (bad < 0 && (plot !== 1'b1 || x !== ex || y !== ey ||
                            colour !== col)) begin
                bad = i;
                $display("FAIL %s pixel %0d: got p=%b x=%0d y=%0d c=%b expected p=1 x=%0d y=%0d c=%b",
                         name, i, plot, x, y, colour, ex, ey, col);
            end
            if (i == chg_at) key_n = chg_val;
            step();
        end
        vecs++;
        if (bad >= 0) errs++;
        chk({name, " plot end"}, 32'(plot), 0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        step();
        while ((busy !== 1'b0 || pending !== 3'b000) && n < 400) begin
            step();
            n++;
        end
        chk({name, " idle"}, {busy, pending}, 0);
    endtask

    initial begin
        int n;
        int p0;

        tbl[0] = '{kn: 3'b101, key: 1, col: 3'b010};
        tbl[1] = '{kn: 3'b111, key: 1, col: 3'b000};
        tbl[2] = '{kn: 3'b011, key: 2, col: 3'b001};
        tbl[3] = '{kn: 3'b111, key: 2, col: 3'b000};
        tbl[4] = '{kn: 3'b110, key: 0, col: 3'b100};
        tbl[5] = '{kn: 3'b111, key: 0, col: 3'b000};

        // reset state and initial repaint
        step();
        step();
        chk("rst plot", 32'(plot), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst x", 32'(x), 0);
        chk("rst y", 32'(y), 87);
        chk("rst colour", 32'(colour), 0);
        chk("rst pending", 32'(pending), 3'b111);
        resetn = 1'b1;
        wait_plot("init0", n);
        chk("init0 lat", n, 2);
        check_fill("init0", 0, 3'b000, -1, 3'b111);
        wait_plot("init1", n);
        chk("init1 gap", n, 2);
        check_fill("init1", 1, 3'b000, -1, 3'b111);
        wait_plot("init2", n);
        chk("init2 gap", n, 2);
        check_fill("init2", 2, 3'b000, -1, 3'b111);
        chk("init busy", 32'(busy), 0);
        chk("init pending", 32'(pending), 0);

        // single-key events from idle
        for (int i = 0; i < 6; i++) begin
            key_n = tbl[i].kn;
            step();
            chk($sformatf("v%0d e0 busy", i), 32'(busy), 0);
            step();
            chk($sformatf("v%0d load busy", i), 32'(busy), 1);
            chk($sformatf("v%0d load plot", i), 32'(plot), 0);
            step();
            check_fill($sformatf("v%0d", i), tbl[i].key, tbl[i].col,
                       -1, 3'b111);
            chk($sformatf("v%0d busy end", i), 32'(busy), 0);
        end

        // keys 0 and 2 together with rr at 1
        key_n = 3'b010;
        wait_plot("dual a", n);
        chk("dual lat", n, 3);
        check_fill("dual k2", 2, 3'b001, -1, 3'b111);
        wait_plot("dual b", n);
        chk("dual gap", n, 2);
        check_fill("dual k0", 0, 3'b100, -1, 3'b111);
        chk("dual busy", 32'(busy), 0);

        // key 1 released during its own draw
        p0 = plot_cnt;
        key_n = 3'b000;
        wait_plot("redo a", n);
        chk("redo lat", n, 3);
        check_fill("redo k1 on", 1, 3'b010, 20, 3'b010);
        wait_plot("redo b", n);
        chk("redo gap", n, 2);
        check_fill("redo k1 off", 1, 3'b000, -1, 3'b111);
        chk("redo pulses", plot_cnt - p0, 128);

        // enable gating
        key_n = 3'b111;
        wait_idle("pre en");
        enable = 1'b0;
        p0 = plot_cnt;
        key_n = 3'b110;
        repeat (10) step();
        chk("en0 pending", 32'(pending), 3'b001);
        chk("en0 busy", 32'(busy), 0);
        chk("en0 pulses", plot_cnt - p0, 0);
        enable = 1'b1;
        step();
        chk("en1 load plot", 32'(plot), 0);
        chk("en1 load busy", 32'(busy), 1);
        step();
        check_fill("en1 k0", 0, 3'b100, -1, 3'b111);

        // reset in the middle of a draw
        key_n = 3'b111;
        wait_plot("mid", n);
        repeat (30) step();
        chk("mid x", 32'(x), 6);
        chk("mid y", 32'(y), 90);
        resetn = 1'b0;
        step();
        chk("mrst plot", 32'(plot), 0);
        chk("mrst busy", 32'(busy), 0);
        chk("mrst pending", 32'(pending), 3'b111);
        chk("mrst x", 32'(x), 0);
        chk("mrst y", 32'(y), 87);
        chk("mrst colour", 32'(colour), 0);
        key_n = 3'b101;
        resetn = 1'b1;
        wait_plot("rp0", n);
        chk("rp0 lat", n, 2);
        check_fill("rp0", 0, 3'b000, -1, 3'b111);
        wait_plot("rp1", n);
        chk("rp1 gap", n, 2);
        check_fill("rp1", 1, 3'b010, -1, 3'b111);
        wait_plot("rp2", n);
        chk("rp2 gap", n, 2);
        check_fill("rp2", 2, 3'b000, -1, 3'b111);
        chk("rp busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
